// File: rtl/cpu_pkg.sv
// Shared definitions for the Execute-stage forwarding controller.
//   DW          datapath width
//   RW          register-address width (8 GPRs)
//   slot_meta_t destination metadata carried by a pipeline slot
package cpu_pkg;

    localparam int DW = 16;
    localparam int RW = 3;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic          we;
        logic          ld;
        logic          v;
    } slot_meta_t;

endpackage

// File: rtl/fwd_match.sv
// Producer/consumer match for one pipeline slot and one source register.
// Ports:
//   v, we, rd  in   destination metadata of the producing slot
//   src        in   source register of the consuming instruction
//   hit        out  the slot holds a valid write to src
module fwd_match
    import cpu_pkg::*;
(
    input  logic          v,
    input  logic          we,
    input  logic [RW-1:0] rd,
    input  logic [RW-1:0] src,
    output logic          hit
);

    // r0 is an ordinary register here, so no zero-register suppression.
    assign hit = v & we & (rd == src);

endmodule

// File: rtl/ex_forward_ctrl.sv
// Execute-stage forwarding controller. Tracks destination metadata for the
// instructions in EX, MEM and WB, selects forwarded operands for the ALU,
// detects load-use hazards and freezes all tracking while the divider runs.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   IdValid, IdRs, IdRt,     decoding instruction entering EX on the next edge
//   IdRd, IdRegWrite, IdMemRead
//   Flush                    instruction entering EX becomes a bubble
//   DivStall                 freeze every slot
//   ALUOut                   result of the instruction in EX
//   MemData                  load data of the instruction in MEM
//   ForwardRs, ForwardRt     select forwarded operand for ALU A / B
//   RsForwarding, RtForwarding  forwarded operand values
//   LoadStall                hold PC/IF/ID one cycle, bubble into EX
module ex_forward_ctrl
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          IdValid,
    input  logic [RW-1:0] IdRs,
    input  logic [RW-1:0] IdRt,
    input  logic [RW-1:0] IdRd,
    input  logic          IdRegWrite,
    input  logic          IdMemRead,
    input  logic          Flush,
    input  logic          DivStall,
    input  logic [DW-1:0] ALUOut,
    input  logic [DW-1:0] MemData,
    output logic          ForwardRs,
    output logic          ForwardRt,
    output logic [DW-1:0] RsForwarding,
    output logic [DW-1:0] RtForwarding,
    output logic          LoadStall
);

    slot_meta_t    ex_meta;
    logic [RW-1:0] ex_rs;
    logic [RW-1:0] ex_rt;

    slot_meta_t    mem_meta;
    logic [DW-1:0] mem_alu;

    // WB never needs the load flag: its value is already resolved.
    logic [RW-1:0] wb_rd;
    logic          wb_we;
    logic          wb_v;
    logic [DW-1:0] wb_val;

    logic          ex_v_next;
    logic          hit_m_rs;
    logic          hit_w_rs;
    logic          hit_m_rt;
    logic          hit_w_rt;
    logic [DW-1:0] mem_fwd_val;

    // Load in EX feeding the decoding instruction: its data only exists
    // once the load reaches MEM, so the consumer waits one cycle.
    assign LoadStall = IdValid & ex_meta.v & ex_meta.ld & ex_meta.we &
                       ((ex_meta.rd == IdRs) | (ex_meta.rd == IdRt)) & ~DivStall;

    assign ex_v_next = IdValid & ~Flush & ~LoadStall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_meta  <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            mem_meta <= '0;
            mem_alu  <= '0;
            wb_rd    <= '0;
            wb_we    <= 1'b0;
            wb_v     <= 1'b0;
            wb_val   <= '0;
        end else if (!DivStall) begin
            wb_rd    <= mem_meta.rd;
            wb_we    <= mem_meta.we;
            wb_v     <= mem_meta.v;
            wb_val   <= mem_meta.ld ? MemData : mem_alu;

            mem_meta <= ex_meta;
            mem_alu  <= ALUOut;

            // A bubble must never look like a producer, so we/ld follow v.
            ex_meta.rd <= IdRd;
            ex_meta.we <= IdRegWrite & ex_v_next;
            ex_meta.ld <= IdMemRead & ex_v_next;
            ex_meta.v  <= ex_v_next;
            ex_rs      <= IdRs;
            ex_rt      <= IdRt;
        end
    end

    fwd_match u_match_mem_rs (
        .v   (mem_meta.v),
        .we  (mem_meta.we),
        .rd  (mem_meta.rd),
        .src (ex_rs),
        .hit (hit_m_rs)
    );

    fwd_match u_match_wb_rs (
        .v   (wb_v),
        .we  (wb_we),
        .rd  (wb_rd),
        .src (ex_rs),
        .hit (hit_w_rs)
    );

    fwd_match u_match_mem_rt (
        .v   (mem_meta.v),
        .we  (mem_meta.we),
        .rd  (mem_meta.rd),
        .src (ex_rt),
        .hit (hit_m_rt)
    );

    fwd_match u_match_wb_rt (
        .v   (wb_v),
        .we  (wb_we),
        .rd  (wb_rd),
        .src (ex_rt),
        .hit (hit_w_rt)
    );

    // A load sitting in MEM forwards the live memory read data.
    assign mem_fwd_val = mem_meta.ld ? MemData : mem_alu;

    // MEM is checked first: the younger producer holds the current value.
    always_comb begin
        ForwardRs    = 1'b0;
        RsForwarding = '0;
        ForwardRt    = 1'b0;
        RtForwarding = '0;
        if (ex_meta.v) begin
            if (hit_m_rs) begin
                ForwardRs    = 1'b1;
                RsForwarding = mem_fwd_val;
            end else if (hit_w_rs) begin
                ForwardRs    = 1'b1;
                RsForwarding = wb_val;
            end
            if (hit_m_rt) begin
                ForwardRt    = 1'b1;
                RtForwarding = mem_fwd_val;
            end else if (hit_w_rt) begin
                ForwardRt    = 1'b1;
                RtForwarding = wb_val;
            end
        end
    end

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Bench for ex_forward_ctrl: directed scenarios plus randomized traffic,
// checked against an instruction-level reference model through a scoreboard.
module tb_ex_forward_ctrl;
    import cpu_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          IdValid = 1'b0;
    logic [RW-1:0] IdRs = '0;
    logic [RW-1:0] IdRt = '0;
    logic [RW-1:0] IdRd = '0;
    logic          IdRegWrite = 1'b0;
    logic          IdMemRead = 1'b0;
    logic          Flush = 1'b0;
    logic          DivStall = 1'b0;
    logic [DW-1:0] ALUOut = '0;
    logic [DW-1:0] MemData = '0;
    logic          ForwardRs;
    logic          ForwardRt;
    logic [DW-1:0] RsForwarding;
    logic [DW-1:0] RtForwarding;
    logic          LoadStall;

    always #5 clk = ~clk;

    ex_forward_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .IdValid      (IdValid),
        .IdRs         (IdRs),
        .IdRt         (IdRt),
        .IdRd         (IdRd),
        .IdRegWrite   (IdRegWrite),
        .IdMemRead    (IdMemRead),
        .Flush        (Flush),
        .DivStall     (DivStall),
        .ALUOut       (ALUOut),
        .MemData      (MemData),
        .ForwardRs    (ForwardRs),
        .ForwardRt    (ForwardRt),
        .RsForwarding (RsForwarding),
        .RtForwarding (RtForwarding),
        .LoadStall    (LoadStall)
    );

    // Reference model: the in-flight instructions, youngest first.
    // inflight[0] is executing, [1] and [2] are older producers. val holds the
    // instruction's result as soon as it is known.
    typedef struct {
        bit        v;
        bit [2:0]  rs, rt, rd;
        bit        we, ld;
        bit [15:0] val;
    } instr_t;

    typedef struct {
        bit        frs, frt;
        bit [15:0] drs, drt;
        bit        ls;
    } exp_t;

    instr_t inflight[3];
    exp_t   sb[$];
    exp_t   last_exp;
    exp_t   mon_e;
    int     n_pass  = 0;
    int     n_total = 0;

    function automatic void clear_model();
        for (int k = 0; k < 3; k++) inflight[k] = '{default: 0};
    endfunction

    // Youngest older writer of src supplies the operand; a load still in
    // memory supplies the live read data.
    function automatic void lookup(input bit [2:0] src, input bit [15:0] md,
                                   output bit f, output bit [15:0] d);
        f = 0;
        d = 0;
        if (inflight[0].v) begin
            for (int k = 1; k < 3; k++) begin
                if (!f && inflight[k].v && inflight[k].we && inflight[k].rd == src) begin
                    f = 1;
                    d = (k == 1 && inflight[k].ld) ? md : inflight[k].val;
                end
            end
        end
    endfunction

    function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endfunction

    task automatic step(input bit r, input bit iv, input bit [2:0] rs, input bit [2:0] rt,
                        input bit [2:0] rd, input bit iw, input bit il,
                        input bit [15:0] alu, input bit [15:0] md, input bit fl, input bit dv);
        instr_t nx, m, w;
        exp_t   e;
        @(negedge clk);
        rst = r; IdValid = iv; IdRs = rs; IdRt = rt; IdRd = rd;
        IdRegWrite = iw; IdMemRead = il; ALUOut = alu; MemData = md;
        Flush = fl; DivStall = dv;
        if (r) clear_model();
        #1;
        lookup(inflight[0].rs, md, e.frs, e.drs);
        lookup(inflight[0].rt, md, e.frt, e.drt);
        e.ls = iv && inflight[0].v && inflight[0].ld && inflight[0].we &&
               (inflight[0].rd == rs || inflight[0].rd == rt) && !dv;
        sb.push_back(e);
        last_exp = e;
        @(posedge clk);
        if (!r && !dv) begin
            nx.v   = iv && !fl && !e.ls;
            nx.rs  = rs;
            nx.rt  = rt;
            nx.rd  = rd;
            nx.we  = iw && nx.v;
            nx.ld  = il && nx.v;
            nx.val = 0;
            w = inflight[1];
            if (w.ld) w.val = md;
            m = inflight[0];
            m.val = alu;
            inflight[2] = w;
            inflight[1] = m;
            inflight[0] = nx;
        end
    endtask

    task automatic ins(input bit [2:0] rs, input bit [2:0] rt, input bit [2:0] rd,
                       input bit iw, input bit il, input bit [15:0] alu, input bit [15:0] md);
        step(0, 1, rs, rt, rd, iw, il, alu, md, 0, 0);
    endtask

    task automatic nop(input bit [15:0] alu, input bit [15:0] md);
        step(0, 0, 0, 0, 0, 0, 0, alu, md, 0, 0);
    endtask

    always @(negedge clk) begin
        #3;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("forward_rs", {15'd0, ForwardRs}, {15'd0, mon_e.frs});
            chk("forward_rt", {15'd0, ForwardRt}, {15'd0, mon_e.frt});
            chk("rs_forwarding", RsForwarding, mon_e.drs);
            chk("rt_forwarding", RtForwarding, mon_e.drt);
            chk("load_stall", {15'd0, LoadStall}, {15'd0, mon_e.ls});
        end
    end

    initial begin
        bit       hold;
        bit       iv, iw, il, fl, dv, r;
        bit [2:0] rs, rt, rd;

        clear_model();
        step(1, 0, 0, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0);
        step(1, 1, 1, 1, 1, 1, 1, 16'hAAAA, 16'h5555, 0, 0);

        // back-to-back ALU dependency forwarded from MEM
        ins(2, 3, 1, 1, 0, 16'h0000, 16'h0000);
        ins(1, 3, 2, 1, 0, 16'h1234, 16'h0000);
        nop(16'h5555, 16'h0000);
        nop(16'h0000, 16'h0000);
        nop(16'h0000, 16'h0000);

        // one-apart dependency on Rt forwarded from WB
        ins(0, 0, 1, 1, 0, 16'h0000, 16'h0000);
        nop(16'h0005, 16'h0000);
        ins(3, 1, 5, 1, 0, 16'h7777, 16'h0000);
        nop(16'h0000, 16'h0000);
        nop(16'h0000, 16'h0000);

        // two producers of r4: the younger (MEM) wins
        ins(0, 0, 4, 1, 0, 16'h0000, 16'h0000);
        ins(0, 0, 4, 1, 0, 16'h1111, 16'h0000);
        ins(4, 4, 6, 1, 0, 16'h2222, 16'h0000);
        nop(16'h0000, 16'h0000);
        nop(16'h0000, 16'h0000);

        // load-use: one stall cycle, then load data from WB
        ins(0, 0, 2, 1, 1, 16'h0000, 16'h0000);
        ins(2, 5, 7, 1, 0, 16'h0000, 16'h0000);
        ins(2, 5, 7, 1, 0, 16'h0000, 16'hBEEF);
        nop(16'h0000, 16'h0000);
        nop(16'h0000, 16'h0000);

        // divider stall with toggling ALUOut and ignored Flush
        ins(0, 0, 3, 1, 0, 16'h0000, 16'h0000);
        ins(3, 3, 4, 1, 0, 16'h3333, 16'h0000);
        for (int i = 0; i < 16; i++)
            step(0, 1, 4, 3, 6, 1, 0, (i % 2) ? 16'hFFFF : 16'h0000,
                 16'($urandom), (i % 4) == 1, 1);
        ins(4, 3, 6, 1, 0, 16'h4444, 16'h0000);
        nop(16'h0000, 16'h0000);
        nop(16'h0000, 16'h0000);

        // flushed producer is not forwarded
        step(0, 1, 0, 0, 5, 1, 0, 16'h0000, 16'h0000, 1, 0);
        ins(5, 5, 0, 1, 0, 16'h0000, 16'h0000);
        nop(16'h0000, 16'h0000);

        // reset asserted in the middle of a divider stall
        ins(0, 0, 7, 1, 0, 16'h0000, 16'h0000);
        ins(7, 7, 1, 1, 0, 16'h9999, 16'h0000);
        step(0, 1, 1, 1, 2, 1, 0, 16'h0000, 16'h0000, 0, 1);
        step(0, 1, 1, 1, 2, 1, 0, 16'h0000, 16'h0000, 0, 1);
        step(1, 1, 1, 1, 2, 1, 0, 16'h0000, 16'h0000, 0, 1);
        step(0, 1, 1, 1, 2, 1, 0, 16'h0000, 16'h0000, 0, 1);
        step(0, 1, 1, 1, 2, 1, 0, 16'h0000, 16'h0000, 0, 0);

        // randomized traffic; decode holds its instruction while stalled
        hold = 0;
        iv = 0; iw = 0; il = 0; rs = 0; rt = 0; rd = 0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                iv = $urandom_range(0, 9) < 8;
                rs = 3'($urandom_range(0, 3));
                rt = 3'($urandom_range(0, 3));
                rd = 3'($urandom_range(0, 3));
                iw = $urandom_range(0, 9) < 7;
                il = $urandom_range(0, 9) < 3;
            end
            fl = $urandom_range(0, 9) == 0;
            dv = $urandom_range(0, 7) == 0;
            r  = $urandom_range(0, 199) == 0;
            step(r, iv, rs, rt, rd, iw, il, 16'($urandom), 16'($urandom), fl, dv);
            hold = iv && !r && (last_exp.ls || dv);
        end

        @(negedge clk);
        #5;
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
